// File: rtl/dadda_mult4_pipe.sv
// dadda_mult4_pipe: registered 4x4 unsigned multiplier built from a Dadda reduction tree
module dadda_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

module dadda_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ z;
  assign co = (x & y) | (z & (x ^ y));
endmodule

module dadda_mult4_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] op,
  output logic       out_valid
);
  logic [3:0] a_r, b_r;
  logic       v0;
  logic [3:0] pp [4];
  logic       s3a, c4a, s4a, c5a;
  logic       s2, c3, s3, c4, s4, c5, s5, c6;
  logic [6:0] x, y, s, rc;
  logic [7:0] core;
  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = a_r & {4{b_r[i]}};
  end
  // stage 1 brings the tallest columns (weights 3 and 4) down to height 3
  dadda_ha u_h3a (.x(pp[0][3]), .y(pp[1][2]), .s(s3a), .co(c4a));
  dadda_ha u_h4a (.x(pp[1][3]), .y(pp[2][2]), .s(s4a), .co(c5a));
  // stage 2 leaves every column at height 2 for the final adder
  dadda_ha u_h2 (.x(pp[0][2]), .y(pp[1][1]), .s(s2), .co(c3));
  dadda_fa u_f3 (.x(s3a), .y(pp[2][1]), .z(pp[3][0]), .s(s3), .co(c4));
  dadda_fa u_f4 (.x(s4a), .y(pp[3][1]), .z(c4a), .s(s4), .co(c5));
  dadda_fa u_f5 (.x(pp[2][3]), .y(pp[3][2]), .z(c5a), .s(s5), .co(c6));
  assign x = {pp[3][3], s5, s4, s3, s2, pp[0][1], pp[0][0]};
  assign y = {c6, c5, c4, c3, pp[2][0], pp[1][0], 1'b0};
  // both bit-7 row entries are zero, so the carry out of bit 6 is product bit 7
  dadda_ha u_r0 (.x(x[0]), .y(y[0]), .s(s[0]), .co(rc[0]));
  for (genvar i = 1; i < 7; i++) begin : g_rca
    dadda_fa u_r (.x(x[i]), .y(y[i]), .z(rc[i-1]), .s(s[i]), .co(rc[i]));
  end
  assign core = {rc[6], s};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      v0        <= 1'b0;
      op        <= '0;
      out_valid <= 1'b0;
    end else begin
      a_r       <= a;
      b_r       <= b;
      v0        <= in_valid;
      op        <= core;
      out_valid <= v0;
    end
  end
endmodule

// File: tb/tb_dadda_mult4_pipe.sv
// tb_dadda_mult4_pipe: table vectors and streams checked through a latency-aware scoreboard
module tb_dadda_mult4_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] op;
  logic       out_valid;

  typedef struct { logic [7:0] p; int c; } exp_t;
  typedef struct { logic [3:0] a; logic [3:0] b; logic [7:0] p; } vec_t;

  exp_t q [$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  dadda_mult4_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .op(op), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid cyc=%0d op=%0d got out_valid=1 required 0", cyc, op);
      end else begin
        e = q.pop_front();
        if (op !== e.p || cyc != e.c) begin
          fails++;
          $display("FAIL product cyc=%0d got op=%0d required op=%0d at cyc=%0d", cyc, op, e.p, e.c);
        end
      end
    end else if (q.size() > 0 && q[0].c <= cyc) begin
      checks++;
      fails++;
      $display("FAIL missing_valid cyc=%0d got out_valid=0 required 1 with op=%0d", cyc, q[0].p);
      void'(q.pop_front());
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] p);
    exp_t e;
    in_valid = v;
    a = ai;
    b = bi;
    if (v && !rst) begin
      e.p = p;
      e.c = cyc + 2;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_out();
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (op !== 8'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s got op=%0d out_valid=%0b required op=0 out_valid=0", name, op, out_valid);
    end
  endtask

  vec_t vt [7];
  logic [3:0] ra, rb;

  initial begin
    vt[0] = '{4'd15, 4'd14, 8'd210};
    vt[1] = '{4'd0,  4'd0,  8'd0};
    vt[2] = '{4'd15, 4'd15, 8'd225};
    vt[3] = '{4'd1,  4'd15, 8'd15};
    vt[4] = '{4'd15, 4'd0,  8'd0};
    vt[5] = '{4'd8,  4'd8,  8'd64};
    vt[6] = '{4'd5,  4'd13, 8'd65};
    #1 check_reset("power_on_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 4'd0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, vt[i].a, vt[i].b, vt[i].p);
      for (int k = 0; k < 3; k++) cycle(1'b0, 4'd3, 4'd3, 8'd0);
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        cycle(1'b1, 4'(i), 4'(j), 8'(i * j));
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      cycle(1'(i % 2 == 0 || i % 7 == 3), ra, rb, {4'd0, ra} * {4'd0, rb});
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 9), 4'd11, 8'((i + 9) * 11));
    #2 rst = 1'b1;
    #1 check_reset("async_reset_full_pipe");
    q.delete();
    cycle(1'b0, 4'd0, 4'd0, 8'd0);
    check_reset("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'd2, 4'd2, 8'd0);
    in_valid = 1'b1;
    a = 4'd3;
    b = 4'd5;
    @(posedge clk);
    cyc++;
    a = 4'd6;
    b = 4'd2;
    #2 rst = 1'b1;
    #1 check_reset("mid_stream_reset");
    q.delete();
    @(negedge clk);
    check_out();
    cycle(1'b1, 4'd4, 4'd4, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'd1, 4'd1, 8'd0);
    cycle(1'b1, 4'd7, 4'd9, 8'd63);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 4'd0, 8'd0);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending products required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
